fetch_seq: RTL

Fetch sequencer sitting in front of the IF stage. Owns the fetch PC and drives the request/acknowledge handshake to a variable-latency instruction memory. Delivers one instruction per cycle to ID through an output register plus a one-entry skid buffer. Applies stall back-pressure and redirects: branch/jump, exception entry and eret.

---
 rtl/fetch_pkg.sv | 34 +++
 rtl/fetch_skid.sv | 59 +++++
 rtl/fetch_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the fetch sequencer: FSM
//               state encoding, default reset/exception addresses, the NOP
//               word and the output/skid entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    // One fetched instruction as held by the output register or the skid
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } fetch_entry_t;

    // A fetch target is misaligned when it is not word aligned
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid
// Description : One-entry skid buffer holding an instruction word, its pc
//               and its address-error flag. Load wins over unload/flush so
//               a flush and a new entry can land in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_adel,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_adel
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_adel;

    // Buffer occupancy and contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= C_NOP;
            r_pc    <= 32'h0;
            r_adel  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_adel  <= i_adel;
        end else if (i_unload || i_flush) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_adel  = r_adel;

    // A live entry must never be overwritten
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        i_load |-> (!r_valid || i_unload || i_flush))
        else $error("fetch_skid: load into occupied skid");

endmodule
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq
// Description : Fetch sequencer. Owns the fetch pc, runs the req/ack
//               handshake to instruction memory, delivers one instruction
//               per cycle through an output register plus a one-entry skid,
//               and handles stall, branch redirect, exception entry and eret.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] EXC_PC   = C_EXC_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        adel
);

    logic [1:0]   r_state,    w_state_nxt;
    logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
    logic         r_req,      w_req_nxt;
    logic [31:0]  r_addr,     w_addr_nxt;
    logic         r_halt,     w_halt_nxt;
    logic         r_valid,    w_valid_nxt;
    fetch_entry_t r_out,      w_out_nxt;

    logic         w_consume;
    logic         w_redir;
    logic [31:0]  w_target;
    logic         w_tgt_bad;
    logic         w_ack;
    logic         w_take_ack;
    logic         w_out_free;
    logic [31:0]  w_pc_inc;
    fetch_entry_t w_ack_entry;
    fetch_entry_t w_adel_entry;
    fetch_entry_t w_skid_q;
    fetch_entry_t w_skid_din;

    logic         w_skid_load;
    logic         w_skid_unload;
    logic         w_skid_flush;
    logic         w_skid_valid;
    logic [31:0]  w_skid_instr;
    logic [31:0]  w_skid_pc;
    logic         w_skid_adel;

    // After a misaligned target only an exception restarts fetching
    assign w_consume    = r_valid && !stall;
    assign w_redir      = (r_state != S_IDLE) && (exc || (!r_halt && (eret || redirect)));
    assign w_target     = exc ? EXC_PC : (eret ? epc : redirect_pc);
    assign w_tgt_bad    = is_misaligned(w_target[1:0]);
    assign w_ack        = r_req && imem_ack;
    assign w_take_ack   = w_ack && (r_state == S_FETCH) && !w_redir;
    assign w_out_free   = !r_valid || w_consume || (exc && w_redir);
    assign w_pc_inc     = r_fetch_pc + 32'd4;
    assign w_ack_entry  = '{instr: imem_rdata, pc: r_addr, adel: 1'b0};
    assign w_adel_entry = '{instr: C_NOP, pc: w_target, adel: 1'b1};
    assign w_skid_q     = '{instr: w_skid_instr, pc: w_skid_pc, adel: w_skid_adel};

    // Output register / skid routing: skid drains first, then fresh ack data
    always_comb begin
        w_valid_nxt   = r_valid;
        w_out_nxt     = r_out;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_flush  = 1'b0;
        w_skid_din    = w_ack_entry;
        if (w_redir) begin
            w_skid_flush = 1'b1;
            if (w_tgt_bad) begin
                if (w_out_free) begin
                    w_valid_nxt = 1'b1;
                    w_out_nxt   = w_adel_entry;
                end else begin
                    w_skid_load = 1'b1;
                    w_skid_din  = w_adel_entry;
                end
            end else if (w_out_free) begin
                w_valid_nxt = 1'b0;
            end
        end else if (w_out_free) begin
            if (w_skid_valid) begin
                w_valid_nxt   = 1'b1;
                w_out_nxt     = w_skid_q;
                w_skid_unload = 1'b1;
            end else if (w_take_ack) begin
                w_valid_nxt = 1'b1;
                w_out_nxt   = w_ack_entry;
            end else begin
                w_valid_nxt = 1'b0;
            end
        end else if (w_take_ack) begin
            w_skid_load = 1'b1;
        end
    end

    // Fetch FSM and request generation; req/addr only change after an ack
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_halt_nxt     = r_halt;
        if (r_state == S_IDLE) begin
            w_state_nxt = S_FETCH;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_fetch_pc;
        end else if (w_redir) begin
            w_fetch_pc_nxt = w_target;
            w_halt_nxt     = w_tgt_bad;
            if (r_req && !imem_ack) begin
                w_state_nxt = S_DRAIN;
            end else begin
                w_state_nxt = S_FETCH;
                w_req_nxt   = !w_tgt_bad;
                w_addr_nxt  = w_target;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_take_ack) begin
                        w_fetch_pc_nxt = w_pc_inc;
                        w_addr_nxt     = w_pc_inc;
                        if (w_out_free) begin
                            w_req_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_FULL;
                            w_req_nxt   = 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        w_state_nxt = S_FETCH;
                        w_req_nxt   = !r_halt;
                        w_addr_nxt  = r_fetch_pc;
                    end
                end
                S_FULL: begin
                    if (w_consume) begin
                        w_state_nxt = S_FETCH;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_fetch_pc;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, request and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_halt     <= 1'b0;
            r_valid    <= 1'b0;
            r_out      <= '{instr: C_NOP, pc: RESET_PC, adel: 1'b0};
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_halt     <= w_halt_nxt;
            r_valid    <= w_valid_nxt;
            r_out      <= w_out_nxt;
        end
    end

    fetch_skid u_skid (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (w_skid_flush),
        .i_instr  (w_skid_din.instr),
        .i_pc     (w_skid_din.pc),
        .i_adel   (w_skid_din.adel),
        .o_valid  (w_skid_valid),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc),
        .o_adel   (w_skid_adel)
    );

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign valid     = r_valid;
    assign instr     = r_out.instr;
    assign pc        = r_out.pc;
    assign adel      = r_out.adel;

    // ID may only branch or return while it holds a live instruction
    a_redir_needs_valid: assert property (@(posedge clk) disable iff (reset)
        (redirect || eret) |-> r_valid)
        else $error("fetch_seq: redirect/eret without valid instruction");

    // An unacknowledged request keeps req and addr stable
    a_req_stable: assert property (@(posedge clk) disable iff (reset)
        (r_req && !imem_ack) |=> (r_req && $stable(r_addr)))
        else $error("fetch_seq: request changed before ack");

endmodule
`default_nettype wire
